// File: rtl/serdes_comma_aligner.sv
// serdes_comma_aligner: serial-to-parallel front end for the 8b/10b receive
// path. Shifts in one bit per qualified clock, hunts for a K28.5 comma, fixes
// the symbol boundary and emits aligned symbols. A small FSM tracks lock:
// HUNT -> ALIGN -> LOCKED on repeated on-boundary commas, back to HUNT on
// repeated misaligned commas while locked.
module serdes_comma_aligner #(
   parameter int               SYM_W    = 10,
   parameter logic [SYM_W-1:0] COMMA_N  = 10'b0101111100,
   parameter logic [SYM_W-1:0] COMMA_P  = 10'b1010000011,
   parameter int               LOCK_CNT = 3,
   parameter int               LOS_CNT  = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inputdata_i,
   input  logic             bit_valid_i,
   output logic [SYM_W-1:0] sym_o,
   output logic             sym_valid_o,
   output logic             comma_o,
   output logic             lock_o,
   output logic [7:0]       realign_cnt_o
);

   localparam int CW  = (SYM_W > 1) ? $clog2(SYM_W) : 1;
   localparam int CCW = $clog2(LOCK_CNT + 1);
   localparam int ECW = $clog2(LOS_CNT + 1);

   typedef enum logic [1:0] {HUNT, ALIGN, LOCKED} state_t;

   state_t           state_q, state_d;
   logic [SYM_W-1:0] sr_q, sr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CCW-1:0]   cc_q, cc_d;
   logic [ECW-1:0]   ec_q, ec_d;
   logic             aligned_q, aligned_d;   // set once the first alignment has happened
   logic [SYM_W-1:0] sym_d;
   logic             sym_valid_d, comma_d, lock_d;
   logic [7:0]       realign_d, realign_inc;

   logic [SYM_W-1:0] w;
   logic             hit, bnd;

   assign w           = {inputdata_i, sr_q[SYM_W-1:1]};
   assign hit         = (w == COMMA_N) || (w == COMMA_P);
   assign bnd         = (cnt_q == CW'(SYM_W - 1));
   assign realign_inc = (realign_cnt_o == 8'hFF) ? 8'hFF : realign_cnt_o + 8'd1;

   // State register plus all datapath registers; everything clears on reset,
   // so a symbol in flight is simply discarded.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= HUNT;
         sr_q          <= '0;
         cnt_q         <= '0;
         cc_q          <= '0;
         ec_q          <= '0;
         aligned_q     <= 1'b0;
         sym_o         <= '0;
         sym_valid_o   <= 1'b0;
         comma_o       <= 1'b0;
         lock_o        <= 1'b0;
         realign_cnt_o <= '0;
      end else begin
         state_q       <= state_d;
         sr_q          <= sr_d;
         cnt_q         <= cnt_d;
         cc_q          <= cc_d;
         ec_q          <= ec_d;
         aligned_q     <= aligned_d;
         sym_o         <= sym_d;
         sym_valid_o   <= sym_valid_d;
         comma_o       <= comma_d;
         lock_o        <= lock_d;
         realign_cnt_o <= realign_d;
      end
   end

   // Next-state and output logic; nothing moves unless the bit is qualified.
   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      cnt_d       = cnt_q;
      cc_d        = cc_q;
      ec_d        = ec_q;
      aligned_d   = aligned_q;
      sym_d       = sym_o;
      sym_valid_d = 1'b0;
      comma_d     = comma_o;
      lock_d      = lock_o;
      realign_d   = realign_cnt_o;

      if (bit_valid_i) begin
         sr_d  = w;
         cnt_d = bnd ? '0 : cnt_q + CW'(1);

         case (state_q)
            HUNT: begin
               if (hit) begin
                  sym_d       = w;
                  sym_valid_d = 1'b1;
                  comma_d     = 1'b1;
                  cnt_d       = '0;
                  cc_d        = CCW'(1);
                  aligned_d   = 1'b1;
                  // only boundary changes after the very first alignment count
                  if (aligned_q) realign_d = realign_inc;
                  if (LOCK_CNT == 1) begin
                     state_d = LOCKED;
                     lock_d  = 1'b1;
                  end else begin
                     state_d = ALIGN;
                  end
               end
            end

            ALIGN: begin
               if (bnd) begin
                  // a comma landing on the boundary confirms it
                  sym_d       = w;
                  sym_valid_d = 1'b1;
                  comma_d     = hit;
                  if (hit) begin
                     cc_d = cc_q + CCW'(1);
                     if (int'(cc_q) + 1 >= LOCK_CNT) begin
                        state_d = LOCKED;
                        lock_d  = 1'b1;
                     end
                  end
               end else if (hit) begin
                  // comma elsewhere: move the boundary onto it
                  sym_d       = w;
                  sym_valid_d = 1'b1;
                  comma_d     = 1'b1;
                  cnt_d       = '0;
                  cc_d        = CCW'(1);
                  realign_d   = realign_inc;
               end
            end

            LOCKED: begin
               if (bnd) begin
                  sym_d       = w;
                  sym_valid_d = 1'b1;
                  comma_d     = hit;
                  if (hit) ec_d = '0;
               end else if (hit) begin
                  // misaligned comma: count it but keep the boundary
                  if (int'(ec_q) + 1 >= LOS_CNT) begin
                     state_d = HUNT;
                     lock_d  = 1'b0;
                     ec_d    = '0;
                     cc_d    = '0;
                  end else begin
                     ec_d = ec_q + ECW'(1);
                  end
               end
            end

            default: state_d = HUNT;
         endcase
      end
   end

endmodule

// File: tb/tb_serdes_comma_aligner.sv
// Bench for serdes_comma_aligner: expected symbols are queued as stimulus is
// driven and popped by a monitor on each sym_valid_o strobe.
module tb_serdes_comma_aligner;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       din = 1'b0;
   logic       bval = 1'b0;
   logic [9:0] sym;
   logic       sym_valid, comma, lock;
   logic [7:0] realign;

   serdes_comma_aligner dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .inputdata_i  (din),
      .bit_valid_i  (bval),
      .sym_o        (sym),
      .sym_valid_o  (sym_valid),
      .comma_o      (comma),
      .lock_o       (lock),
      .realign_cnt_o(realign)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] sym;
      logic       comma;
      logic       lock;
      int         gap;     // valid bits since previous strobe, -1 = unchecked
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   vcnt = 0;
   int   last_v = 0;

   logic [9:0] cn  = 10'b0101111100;
   logic [9:0] cp  = 10'b1010000011;
   logic [9:0] d00 = 10'b1001110100;
   logic [9:0] d77 = 10'b0001110100;
   logic [9:0] d102 = 10'b0101011011;

   // count qualified bits as the DUT samples them
   always @(posedge clk) if (rst_n && bval) vcnt++;

   // scoreboard monitor, sampling away from the active edge
   always @(negedge clk) begin
      if (rst_n && sym_valid) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_strobe: got sym=%h comma=%b lock=%b, none expected", sym, comma, lock);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if ({sym, comma, lock} !== {e.sym, e.comma, e.lock}) begin
               miscompares++;
               $display("FAIL strobe: got sym=%h comma=%b lock=%b, want sym=%h comma=%b lock=%b",
                        sym, comma, lock, e.sym, e.comma, e.lock);
            end
            if (e.gap >= 0) begin
               vectors++;
               if (vcnt - last_v !== e.gap) begin
                  miscompares++;
                  $display("FAIL strobe_gap: got %0d valid bits, want %0d", vcnt - last_v, e.gap);
               end
            end
         end
         last_v = vcnt;
      end
   end

   task automatic push(input logic [9:0] s, input logic c, input logic l, input int g);
      exp_t e;
      e.sym = s; e.comma = c; e.lock = l; e.gap = g;
      exp_q.push_back(e);
   endtask

   task automatic send_bit(input logic b);
      din  = b;
      bval = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic send_sym(input logic [9:0] s);
      for (int i = 0; i < 10; i++) send_bit(s[i]);
   endtask

   task automatic idle(input int n);
      bval = 1'b0;
      for (int i = 0; i < n; i++) begin
         din = 1'($urandom);
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset();
      bval  = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic drain(input string name);
      idle(3);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL %s_missing_strobes: %0d outstanding, want 0", name, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic lock_link();
      do_reset();
      push(cn, 1'b1, 1'b0, -1);
      push(cp, 1'b1, 1'b0, 10);
      push(cn, 1'b1, 1'b1, 10);
      send_sym(cn); send_sym(cp); send_sym(cn);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bval  = 1'b1;
      din   = 1'b1;
      #1;
      vectors++;
      if ({sym, sym_valid, comma, lock, realign} !== 21'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h, want 0", {sym, sym_valid, comma, lock, realign});
      end
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({sym, sym_valid, comma, lock, realign} !== 21'd0) begin
         miscompares++;
         $display("FAIL reset_hold: got %h, want 0", {sym, sym_valid, comma, lock, realign});
      end
      bval = 1'b0;
   endtask

   task automatic test_single_comma();
      do_reset();
      push(10'h17C, 1'b1, 1'b0, -1);
      send_sym(cn);
      drain("single_comma");
      vectors++;
      if (lock !== 1'b0) begin
         miscompares++;
         $display("FAIL single_comma_lock: got %b, want 0", lock);
      end
   endtask

   task automatic test_lock_seq();
      lock_link();
      drain("lock_seq");
      vectors++;
      if ({lock, realign} !== {1'b1, 8'd0}) begin
         miscompares++;
         $display("FAIL lock_seq_state: got lock=%b realign=%0d, want lock=1 realign=0", lock, realign);
      end
   endtask

   task automatic test_data();
      lock_link();
      push(d00,  1'b0, 1'b1, 10);
      push(d77,  1'b0, 1'b1, 10);
      push(d102, 1'b0, 1'b1, 10);
      send_sym(d00); send_sym(d77); send_sym(d102);
      drain("data");
      vectors++;
      if (lock !== 1'b1) begin
         miscompares++;
         $display("FAIL data_lock: got %b, want 1", lock);
      end
   endtask

   task automatic test_misalign();
      logic [9:0] rot;
      rot = {cn[8:0], cn[9]};
      lock_link();
      // one extra 0 bit shifts every following comma one place past the boundary
      push({cn[8:0], 1'b0}, 1'b0, 1'b1, 10);
      push(rot, 1'b0, 1'b1, 10);
      push(rot, 1'b0, 1'b1, 10);
      push(rot, 1'b0, 1'b1, 10);
      push(cn, 1'b1, 1'b0, 11);
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_sym(cn);
      vectors++;
      if ({lock, realign} !== {1'b0, 8'd0}) begin
         miscompares++;
         $display("FAIL misalign_los: got lock=%b realign=%0d, want lock=0 realign=0", lock, realign);
      end
      send_sym(cn);
      drain("misalign");
      vectors++;
      if ({lock, realign} !== {1'b0, 8'd1}) begin
         miscompares++;
         $display("FAIL misalign_realign: got lock=%b realign=%0d, want lock=0 realign=1", lock, realign);
      end
   endtask

   task automatic test_gaps();
      logic [9:0] syms [3];
      syms[0] = d102; syms[1] = d00; syms[2] = d77;
      lock_link();
      for (int s = 0; s < 3; s++) push(syms[s], 1'b0, 1'b1, 10);
      for (int s = 0; s < 3; s++) begin
         for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
            send_bit(syms[s][i]);
         end
      end
      drain("gaps");
      vectors++;
      if ({lock, realign} !== {1'b1, 8'd0}) begin
         miscompares++;
         $display("FAIL gaps_state: got lock=%b realign=%0d, want lock=1 realign=0", lock, realign);
      end
   endtask

   task automatic test_reset_mid();
      lock_link();
      drain("reset_mid_pre");
      for (int i = 0; i < 5; i++) send_bit(d00[i]);
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({sym, sym_valid, comma, lock, realign} !== 21'd0) begin
         miscompares++;
         $display("FAIL reset_mid_outputs: got %h, want 0", {sym, sym_valid, comma, lock, realign});
      end
      bval = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      push(cp, 1'b1, 1'b0, -1);
      send_sym(cp);
      drain("reset_mid");
      vectors++;
      if ({lock, realign} !== {1'b0, 8'd0}) begin
         miscompares++;
         $display("FAIL reset_mid_realign: got lock=%b realign=%0d, want lock=0 realign=0", lock, realign);
      end
   endtask

   initial begin
      test_reset();
      test_single_comma();
      test_lock_seq();
      test_data();
      test_misalign();
      test_gaps();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
